// File: rtl/seq_booth_mul_if.sv
// rtl/seq_booth_mul_if.sv - start/busy/done handshake and operand/product bus of the Booth multiplier
interface seq_booth_mul_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] z_high;
  logic [WIDTH-1:0] z_low;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, z_high, z_low
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, z_high, z_low
  );
endinterface

// File: rtl/seq_booth_mul.sv
// rtl/seq_booth_mul.sv - iterative radix-4 Booth multiplier, one digit per cycle, signed/unsigned
module seq_booth_mul #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           clr,
  seq_booth_mul_if.slave bus
);
  localparam int ITER  = WIDTH / 2 + 1;
  localparam int EW    = WIDTH + 2;
  localparam int ACC_W = 2 * WIDTH + 6;
  localparam int CW    = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [EW-1:0]    mcand_q, mcand_d;
  logic [EW-1:0]    mult_q, mult_d;
  logic             prev_q, prev_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] zh_q, zh_d;
  logic [WIDTH-1:0] zl_q, zl_d;

  logic             accept;
  logic             last_step;
  logic [2:0]       trip;
  logic [ACC_W-1:0] m_ext;
  logic [ACC_W-1:0] pp;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] acc_step;

  assign accept    = bus.start && (state_q != RUN);
  assign last_step = (state_q == RUN) && (cnt_q == CW'(ITER - 1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (state_q == RUN);
    bus.done   = (state_q == DONE);
    bus.z_high = zh_q;
    bus.z_low  = zl_q;
  end

  // Digits are added at weight 2^(2*ITER) so that after ITER right shifts the accumulator holds the product exactly.
  always_comb begin
    m_ext = {{(ACC_W - EW){mcand_q[EW-1]}}, mcand_q};
    trip  = {mult_q[1:0], prev_q};
    case (trip)
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m_ext << 1;
      3'b100:         pp = -(m_ext << 1);
      3'b101, 3'b110: pp = -m_ext;
      default:        pp = '0;
    endcase
    sum      = acc_q + (pp << (2 * ITER));
    acc_step = $signed(sum) >>> 2;
  end

  always_comb begin
    mcand_d = mcand_q;
    mult_d  = mult_q;
    prev_d  = prev_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    zh_d    = zh_q;
    zl_d    = zl_q;
    if (accept) begin
      mcand_d = bus.signed_mode ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
      mult_d  = bus.signed_mode ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};
      prev_d  = 1'b0;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      acc_d  = acc_step;
      mult_d = {2'b00, mult_q[EW-1:2]};
      prev_d = mult_q[1];
      cnt_d  = cnt_q + CW'(1);
      if (last_step) begin
        zh_d = acc_step[2*WIDTH-1:WIDTH];
        zl_d = acc_step[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mcand_q <= '0;
      mult_q  <= '0;
      prev_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      zh_q    <= '0;
      zl_q    <= '0;
    end else begin
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      prev_q  <= prev_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      zh_q    <= zh_d;
      zl_q    <= zl_d;
    end
  end
endmodule

// File: tb/tb_seq_booth_mul.sv
// tb/tb_seq_booth_mul.sv - scoreboard bench for seq_booth_mul at WIDTH=32 and WIDTH=8
module tb_seq_booth_mul;
  logic clk = 1'b0;
  logic clr;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [63:0] q32[$];
  logic [15:0] q8[$];

  always #5 clk = ~clk;

  seq_booth_mul_if #(.WIDTH(32)) bus32();
  seq_booth_mul_if #(.WIDTH(8))  bus8();

  seq_booth_mul #(.WIDTH(32)) dut32 (.clk(clk), .clr(clr), .bus(bus32.slave));
  seq_booth_mul #(.WIDTH(8))  dut8  (.clk(clk), .clr(clr), .bus(bus8.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model32(input logic [31:0] x, input logic [31:0] y, input logic sm);
    logic [63:0] xe, ye;
    xe = sm ? {{32{x[31]}}, x} : {32'b0, x};
    ye = sm ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction

  always @(negedge clk) begin
    if (clr) begin
      if (bus32.busy && bus32.done) check("overlap32", 64'(bus32.done), 64'd0);
      if (bus32.done) begin
        if (q32.size() == 0) check("done32_unexpected", 64'(bus32.done), 64'd0);
        else check("prod32", {bus32.z_high, bus32.z_low}, q32.pop_front());
      end
      if (bus8.done) begin
        if (q8.size() == 0) check("done8_unexpected", 64'(bus8.done), 64'd0);
        else check("prod8", 64'({bus8.z_high, bus8.z_low}), 64'(q8.pop_front()));
      end
    end
  end

  task automatic wait_done32(output int lat, output int nb);
    lat = -1;
    nb  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus32.done) begin
        lat = i;
        break;
      end
      if (bus32.busy) nb++;
    end
    if (lat < 0) check("timeout32", 64'(bus32.done), 64'd1);
  endtask

  task automatic op32(input logic [31:0] x, input logic [31:0] y, input logic sm,
                      input logic [63:0] exp, output int lat, output int nb);
    int n;
    @(posedge clk); #1;
    bus32.start = 1'b1; bus32.a = x; bus32.b = y; bus32.signed_mode = sm;
    q32.push_back(exp);
    @(posedge clk); #1;
    bus32.start = 1'b0;
    wait_done32(lat, n);
    nb = n + (lat > 0 ? 1 : 0);
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic sm,
                     input logic [15:0] exp, output int lat);
    lat = -1;
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.a = x; bus8.b = y; bus8.signed_mode = sm;
    q8.push_back(exp);
    @(posedge clk); #1;
    bus8.start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus8.done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) check("timeout8", 64'(bus8.done), 64'd1);
  endtask

  initial begin
    int lat, nb;
    logic [31:0] rx, ry;
    logic        rs;
    clr = 1'b0;
    bus32.start = 1'b0; bus32.signed_mode = 1'b0; bus32.a = '0; bus32.b = '0;
    bus8.start  = 1'b0; bus8.signed_mode  = 1'b0; bus8.a  = '0; bus8.b  = '0;
    #12;
    check("rst_busy", 64'(bus32.busy), 64'd0);
    check("rst_done", 64'(bus32.done), 64'd0);
    check("rst_z",    {bus32.z_high, bus32.z_low}, 64'd0);
    #10 clr = 1'b1;

    op32(32'h00000007, 32'hFFFFFFFB, 1'b1, 64'hFFFFFFFF_FFFFFFDD, lat, nb);
    check("latency32", 64'(lat), 64'd17);
    check("busy_cycles32", 64'(nb), 64'd17);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(bus32.done), 64'd0);
    check("z_hold", {bus32.z_high, bus32.z_low}, 64'hFFFFFFFF_FFFFFFDD);

    op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, lat, nb);
    op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001, lat, nb);
    op32(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, lat, nb);
    op32(32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000, lat, nb);

    for (int k = 0; k < 8; k++) begin
      rx = $urandom;
      ry = $urandom;
      rs = k[0];
      op32(rx, ry, rs, model32(rx, ry, rs), lat, nb);
    end

    // Back-to-back: operands change and start stays high during RUN.
    @(posedge clk); #1;
    bus32.start = 1'b1; bus32.a = 32'd3; bus32.b = 32'd4; bus32.signed_mode = 1'b0;
    q32.push_back(64'd12);
    @(posedge clk); #1;
    bus32.a = 32'hDEADBEEF; bus32.b = 32'h12345678; bus32.signed_mode = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    check("b2b_done1", 64'(bus32.done), 64'd1);
    q32.push_back(model32(32'hDEADBEEF, 32'h12345678, 1'b1));
    @(posedge clk); #1;
    check("b2b_no_idle", 64'(bus32.busy), 64'd1);
    bus32.start = 1'b0;
    wait_done32(lat, nb);
    check("b2b_latency2", 64'(lat), 64'd17);

    // Asynchronous reset in the middle of RUN.
    @(posedge clk); #1;
    bus32.start = 1'b1; bus32.a = 32'd2; bus32.b = 32'd3; bus32.signed_mode = 1'b0;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    repeat (5) @(posedge clk);
    #3 clr = 1'b0;
    #1;
    check("arst_busy", 64'(bus32.busy), 64'd0);
    check("arst_done", 64'(bus32.done), 64'd0);
    check("arst_z",    {bus32.z_high, bus32.z_low}, 64'd0);
    #10 clr = 1'b1;
    op32(32'd2, 32'd3, 1'b0, 64'd6, lat, nb);
    check("post_rst_latency", 64'(lat), 64'd17);

    op8(8'hFF, 8'h02, 1'b0, 16'h01FE, lat);
    check("latency8", 64'(lat), 64'd5);
    op8(8'h80, 8'h7F, 1'b1, 16'hC080, lat);

    repeat (3) @(posedge clk);
    #1;
    check("q32_drained", 64'(q32.size()), 64'd0);
    check("q8_drained",  64'(q8.size()),  64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_booth_mul.md
# seq_booth_mul

Iterative radix-4 Booth multiplier, parametrised in operand width, with signed and unsigned modes. It is the next-generation multiply unit for the datapath ALU. It captures two WIDTH-bit operands on a start pulse and retires one Booth digit per cycle. It then presents the full 2·WIDTH-bit product split into high and low words, which feed the Z-high/Z-low (or HI/LO) registers on the bus. A start/busy/done handshake lets the control unit sequence it.

## Interface
- WIDTH, 32: operand width. Must be even and ≥ 4.
- ITER (localparam), WIDTH/2 + 1: number of Booth iterations.

- clk  in  1  system clock; all state changes on its rising edge.
- clr  in  1  reset, asynchronous, active-low.
- start  in  1  request a multiply; sampled on the rising edge of clk.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- a  in  WIDTH  multiplicand; captured with start.
- b  in  WIDTH  multiplier; captured with start.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when the product is valid.
- z_high  out  WIDTH  product bits [2·WIDTH-1:WIDTH].
- z_low  out  WIDTH  product bits [WIDTH-1:0].

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE, start=1:
  - Capture a and b, each extended to WIDTH+2 bits. Extension is sign-extension if signed_mode=1, zero-extension otherwise.
  - Clear the accumulator, set the iteration counter to 0, go to RUN.
- RUN, each cycle:
  - Examine the next Booth triplet of the extended multiplier, LSB first, with an implicit 0 below bit 0.
  - Add 0, ±M or ±2M (M = extended multiplicand) to the upper accumulator half.
  - Arithmetic-shift the accumulator right by 2 and increment the counter.
  - After the ITER-th step, register the product into z_high/z_low and go to DONE.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation), transitioning directly to RUN.
- start during RUN is ignored; captured operands and mode are unaffected by input changes during RUN.
- Result rules:
  - Exact product of the captured operands; no truncation or overflow flag.
  - Unsigned mode: product = a·b in [0, (2^WIDTH−1)^2].
  - Signed mode: two's-complement product of width 2·WIDTH.
  - The accumulator must be at least 2·WIDTH+4 bits wide so that ±2M never overflows.
- z_high/z_low hold their value from completion until the next completion or reset. They never show partial products.
- busy=1 exactly in RUN; done=1 exactly in DONE; they are never both high.

## Timing
- Reset (clr=0), asynchronous and immediate:
  - State goes to IDLE.
  - busy=0, done=0, z_high=0, z_low=0; counter and accumulator are cleared.
  - Applies mid-RUN or in DONE; the in-flight operation is discarded.
- After clr returns high, the first rising edge with start=1 begins an operation.
- Latency, counting the start-capture edge as edge 0:
  - busy is high after edges 0..ITER−1.
  - The product is registered at edge ITER.
  - done is high between edges ITER and ITER+1.
  - For WIDTH=32: ITER=17, so done follows the 17th edge after capture.
- Throughput: one product every ITER+1 cycles with start held high continuously.
- Counter width: ceil(log2(ITER+1)) bits. The counter does not wrap within an operation.

## Test plan
- WIDTH=32, signed 0x00000007 × 0xFFFFFFFB (7 × −5) → z_high=0xFFFFFFFF, z_low=0xFFFFFFDD. done pulses for exactly one cycle, 17 edges after capture; busy high for 17 cycles.
- WIDTH=32, 0xFFFFFFFF × 0xFFFFFFFF:
  - unsigned → 0xFFFFFFFE / 0x00000001;
  - signed → 0x00000000 / 0x00000001.
- WIDTH=32, signed 0x80000000 × 0x80000000 → 0x40000000 / 0x00000000. Signed 0x80000000 × 0x00000001 → 0xFFFFFFFF / 0x80000000.
- Capture 3 × 4 unsigned, then change a/b/signed_mode to 0xDEADBEEF / 0x12345678 / 1 and hold start=1 during RUN:
  - the result is 0 / 0x0000000C;
  - the second operation starts from DONE with no IDLE cycle and yields the product of the values present at that edge.
- Drive clr=0 asynchronously, mid-cycle, at RUN iteration 5 → busy, done, z_high and z_low drop to 0 immediately, before the next edge. After release, 2 × 3 completes normally with 0 / 6.
- WIDTH=8, ITER=5:
  - unsigned 0xFF × 0x02 → z_high=0x01, z_low=0xFE, done after edge 5;
  - signed 0x80 × 0x7F → 0xC0 / 0x80.
